// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: one outstanding imem request, redirect/kill handling, sticky timeout error.
// First request 1 cycle after en; inst_valid 1 cycle after accepted ack; HOLD stalls while inst_ready=0.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic [31:0] fetch_pc
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERROR} stateT;

  stateT            state, nextState;
  logic [31:0]      pc, pcNext;
  logic [31:0]      reqAddr;
  logic [31:0]      instReg, instPcReg;
  logic [31:0]      redirTarget;
  logic             kill, killNext;
  logic [CNT_W-1:0] toCnt, toCntNext;
  logic             latchInst;
  logic             loadReqAddr;

  assign redirTarget = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      reqAddr   <= RESET_PC;
      kill      <= 1'b0;
      toCnt     <= '0;
      instReg   <= '0;
      instPcReg <= '0;
    end else begin
      state <= nextState;
      pc    <= pcNext;
      kill  <= killNext;
      toCnt <= toCntNext;
      // The bus address is held separately so a redirect never disturbs an in-flight request.
      if (loadReqAddr) reqAddr <= pcNext;
      if (latchInst) begin
        instReg   <= imem_rdata;
        instPcReg <= pc;
      end
    end
  end

  always_comb begin
    nextState   = state;
    pcNext      = pc;
    killNext    = kill;
    toCntNext   = '0;
    latchInst   = 1'b0;
    loadReqAddr = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pcNext = redirTarget;
        end else if (en) begin
          nextState   = REQ;
          loadReqAddr = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (kill || redirect_valid) begin
            // Stale response: drop it and reissue at the (possibly new) target.
            killNext    = 1'b0;
            if (redirect_valid) pcNext = redirTarget;
            loadReqAddr = 1'b1;
          end else begin
            latchInst = 1'b1;
            pcNext    = pc + 32'd4;
            nextState = HOLD;
          end
        end else begin
          if (redirect_valid) begin
            killNext = 1'b1;
            pcNext   = redirTarget;
          end
          if (toCnt == CNT_W'(TIMEOUT - 1)) nextState = ERROR;
          else                              toCntNext = toCnt + 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pcNext      = redirTarget;
          nextState   = REQ;
          loadReqAddr = 1'b1;
        end else if (inst_ready) begin
          if (en) begin
            nextState   = REQ;
            loadReqAddr = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
      end
      ERROR: begin
        nextState = ERROR;
      end
      default: nextState = IDLE;
    endcase
  end

  assign imem_req   = (state == REQ);
  assign imem_addr  = reqAddr;
  assign inst_valid = (state == HOLD);
  assign inst       = instReg;
  assign inst_pc    = instPcReg;
  assign fetch_err  = (state == ERROR);
  assign fetch_pc   = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance starts at FFFF_FFFC to cover PC wrap.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, imem_ack, inst_ready, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc;

  logic        imem_req, inst_valid, fetch_err;
  logic [31:0] imem_addr, inst, inst_pc, fetch_pc;

  logic        wReq, wValid, wErr;
  logic [31:0] wAddr, wInst, wInstPc, wPc;

  int nAssert = 0;
  int nFail   = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .fetch_pc(fetch_pc)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dutW (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(wReq), .imem_addr(wAddr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(wValid), .inst(wInst), .inst_pc(wInstPc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(wErr), .fetch_pc(wPc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_pc",    fetch_pc,            32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_ipc",   inst_pc,             32'h0);
    chk("rst_err",   {31'd0, fetch_err},  32'd0);
    chk("rst_waddr", wAddr,               32'hFFFF_FFFC);
    chk("rst_wpc",   wPc,                 32'hFFFF_FFFC);
    #9;
    // Zero-wait memory, decode always ready.
    rst = 1'b0; en = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1; imem_rdata = 32'h1000_0000;
    step();
    chk("t1_req0",  {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr,         32'h0);
    chk("wr_addr0", wAddr,             32'hFFFF_FFFC);
    step();
    chk("t1_val0",  {31'd0, inst_valid}, 32'd1);
    chk("t1_inst0", inst,                32'h1000_0000);
    chk("t1_ipc0",  inst_pc,             32'h0);
    chk("t1_noreq", {31'd0, imem_req},   32'd0);
    chk("t1_pc4",   fetch_pc,            32'h4);
    chk("wr_ipc",   wInstPc,             32'hFFFF_FFFC);
    chk("wr_pc0",   wPc,                 32'h0);
    imem_rdata = 32'h1000_0004;
    step();
    chk("t1_addr4", imem_addr,           32'h4);
    chk("t1_val_lo", {31'd0, inst_valid}, 32'd0);
    chk("wr_addr1", wAddr,               32'h0);
    step();
    chk("t1_ipc4",  inst_pc, 32'h4);
    chk("t1_inst4", inst,    32'h1000_0004);
    imem_rdata = 32'h1000_0008;
    step();
    chk("t1_addr8", imem_addr, 32'h8);
    step();
    chk("t1_ipc8",  inst_pc, 32'h8);
    chk("t1_inst8", inst,    32'h1000_0008);
    en = 1'b0;
    step();
    chk("t1_idle_req", {31'd0, imem_req},   32'd0);
    chk("t1_idle_val", {31'd0, inst_valid}, 32'd0);
    chk("t1_idle_pc",  fetch_pc,            32'hC);

    // Ack delayed three cycles, then decode stalls four cycles.
    imem_ack = 1'b0; inst_ready = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_req_hold",  {31'd0, imem_req}, 32'd1);
      chk("t2_addr_hold", imem_addr,         32'hC);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2000_000C;
    step();
    chk("t2_val",  {31'd0, inst_valid}, 32'd1);
    chk("t2_inst", inst,                32'h2000_000C);
    chk("t2_pc",   fetch_pc,            32'h10);
    imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_stall_val",  {31'd0, inst_valid}, 32'd1);
      chk("t2_stall_inst", inst,                32'h2000_000C);
      chk("t2_stall_ipc",  inst_pc,             32'hC);
      chk("t2_stall_req",  {31'd0, imem_req},   32'd0);
    end
    inst_ready = 1'b1;
    step();
    chk("t2_next_req",  {31'd0, imem_req}, 32'd1);
    chk("t2_next_addr", imem_addr,         32'h10);

    // Redirect in the 2nd cycle of an outstanding request; the late ack must be discarded.
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    chk("t3_old_addr", imem_addr,         32'h10);
    chk("t3_new_pc",   fetch_pc,          32'h100);
    chk("t3_req",      {31'd0, imem_req}, 32'd1);
    redirect_valid = 1'b0;
    step();
    imem_ack = 1'b1; imem_rdata = 32'h0000_DEAD;
    step();
    chk("t3_drop_val", {31'd0, inst_valid}, 32'd0);
    chk("t3_reissue",  imem_addr,           32'h100);
    chk("t3_req2",     {31'd0, imem_req},   32'd1);
    imem_rdata = 32'h3000_0100;
    step();
    chk("t3_val",  {31'd0, inst_valid}, 32'd1);
    chk("t3_inst", inst,                32'h3000_0100);
    chk("t3_ipc",  inst_pc,             32'h100);
    imem_ack = 1'b0;

    // Misaligned redirect in HOLD with a same-cycle accept.
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    chk("t4_val",  {31'd0, inst_valid}, 32'd0);
    chk("t4_addr", imem_addr,           32'h200);
    chk("t4_pc",   fetch_pc,            32'h200);
    // Redirect coincident with ack in REQ.
    imem_ack = 1'b1; imem_rdata = 32'h0000_BEEF; redirect_pc = 32'h300;
    step();
    chk("t5_val",  {31'd0, inst_valid}, 32'd0);
    chk("t5_addr", imem_addr,           32'h300);
    chk("t5_req",  {31'd0, imem_req},   32'd1);
    redirect_valid = 1'b0; imem_rdata = 32'h4000_0300;
    step();
    chk("t5_inst", inst,     32'h4000_0300);
    chk("t5_ipc",  inst_pc,  32'h300);
    chk("t5_pc",   fetch_pc, 32'h304);
    imem_ack = 1'b0; en = 1'b0;
    step();
    chk("t5_idle", {31'd0, imem_req}, 32'd0);
    // Redirect in IDLE wins over en.
    redirect_valid = 1'b1; redirect_pc = 32'h402; en = 1'b1;
    step();
    chk("t6_idle_req", {31'd0, imem_req}, 32'd0);
    chk("t6_idle_pc",  fetch_pc,          32'h400);
    redirect_valid = 1'b0;
    step();
    chk("t6_addr", imem_addr, 32'h400);

    // Timeout: request held 16 cycles with no ack.
    repeat (15) step();
    chk("t7_req_last", {31'd0, imem_req},  32'd1);
    chk("t7_err_pre",  {31'd0, fetch_err}, 32'd0);
    step();
    chk("t7_err",   {31'd0, fetch_err},  32'd1);
    chk("t7_req",   {31'd0, imem_req},   32'd0);
    chk("t7_val",   {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h500; imem_ack = 1'b1;
    repeat (3) step();
    chk("t7_sticky", {31'd0, fetch_err}, 32'd1);
    chk("t7_noreq",  {31'd0, imem_req},  32'd0);
    chk("t7_pc",     fetch_pc,           32'h400);
    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    chk("t8_err",  {31'd0, fetch_err}, 32'd0);
    chk("t8_pc",   fetch_pc,           32'h0);
    chk("t8_addr", imem_addr,          32'h0);
    redirect_valid = 1'b0; imem_ack = 1'b0;
    #3 rst = 1'b0;
    step();
    chk("t8_req",  {31'd0, imem_req}, 32'd1);
    chk("t8_addr2", imem_addr,        32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
